// File: rtl/conv_pe_lb.sv
// conv_pe_lb: streaming 3x3 convolution over a raster pixel stream using two line buffers.
// Result lands 3 cycles after the accepting pixel; ready is state-driven and the pipeline never stalls.
module conv_pe_lb #(
  parameter int DATA_W = 9,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reuse_w,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  localparam int PW = 2 * DATA_W;
  localparam int RW = PW + 2;
  localparam int SW = PW + 4;
  localparam int CW = $clog2(IMG_W);
  localparam int HW = $clog2(IMG_H);
  localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  w      [0:8];
  logic [3:0]                wk;
  logic [CW-1:0]             col;
  logic [HW-1:0]             row;
  logic signed [DATA_W-1:0]  lb0    [0:IMG_W-1];
  logic signed [DATA_W-1:0]  lb1    [0:IMG_W-1];
  // The window's oldest column lives only in win_nx; the two newer columns are registered.
  logic signed [DATA_W-1:0]  win    [0:2][1:2];
  logic signed [DATA_W-1:0]  win_nx [0:2][0:2];
  logic signed [PW-1:0]      prod   [0:8];
  logic signed [RW-1:0]      rsum   [0:2];
  logic                      v1, v2, l1, l2;
  logic                      accept, launch, last_pix;
  logic signed [SW-1:0]      sum3, shifted;
  logic [DATA_W-1:0]         clamped;
  logic                      clip;

  assign accept   = (state == S_RUN) && pix_valid;
  assign last_pix = (row == HW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign launch   = accept && (row >= HW'(2)) && (col >= CW'(2));

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nx[r][0] = win[r][1];
      win_nx[r][1] = win[r][2];
    end
    win_nx[0][2] = lb1[IMG_W-1];
    win_nx[1][2] = lb0[IMG_W-1];
    win_nx[2][2] = $signed(pix_data);
  end

  always_comb begin
    sum3    = SW'(rsum[0]) + SW'(rsum[1]) + SW'(rsum[2]);
    shifted = sum3 >>> SHIFT;
    clamped = shifted[DATA_W-1:0];
    clip    = 1'b0;
    if (shifted > MAX_V) begin
      clamped = MAX_V[DATA_W-1:0];
      clip    = 1'b1;
    end else if (shifted < MIN_V) begin
      clamped = MIN_V[DATA_W-1:0];
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      w_ready   <= 1'b0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wk        <= '0;
      col       <= '0;
      row       <= '0;
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          col  <= '0;
          row  <= '0;
          wk   <= '0;
          if (reuse_w) begin
            state     <= S_RUN;
            pix_ready <= 1'b1;
          end else begin
            state   <= S_LOAD_W;
            w_ready <= 1'b1;
          end
        end
        S_LOAD_W: if (w_valid) begin
          w[wk] <= $signed(w_data);
          wk    <= wk + 4'd1;
          if (wk == 4'd8) begin
            state     <= S_RUN;
            w_ready   <= 1'b0;
            pix_ready <= 1'b1;
          end
        end
        S_RUN: if (pix_valid) begin
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (last_pix) begin
            state     <= S_FLUSH;
            pix_ready <= 1'b0;
          end
        end
        S_FLUSH: if (out_valid && out_last) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          w_ready   <= 1'b0;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win[r][1] <= '0;
        win[r][2] <= '0;
        rsum[r]   <= '0;
      end
      for (int i = 0; i < 9; i++) prod[i] <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (accept) begin
        lb0[0] <= $signed(pix_data);
        lb1[0] <= lb0[IMG_W-1];
        for (int i = 1; i < IMG_W; i++) begin
          lb0[i] <= lb0[i-1];
          lb1[i] <= lb1[i-1];
        end
        for (int r = 0; r < 3; r++) begin
          win[r][1] <= win_nx[r][1];
          win[r][2] <= win_nx[r][2];
        end
      end
      v1 <= launch;
      l1 <= launch && last_pix;
      if (launch)
        for (int i = 0; i < 9; i++) prod[i] <= PW'(w[i]) * PW'(win_nx[i/3][i%3]);
      v2 <= v1;
      l2 <= l1;
      if (v1)
        for (int r = 0; r < 3; r++)
          rsum[r] <= RW'(prod[3*r]) + RW'(prod[3*r+1]) + RW'(prod[3*r+2]);
      out_valid <= v2;
      out_last  <= l2;
      if (v2) out_data <= clamped;
      if (state == S_IDLE && start) sat_flag <= 1'b0;
      else if (v2 && clip)          sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_pe_lb.sv
// Self-checking bench for conv_pe_lb on a 4x4 image: directed frames plus randomized frames against a plain-arithmetic model.
module tb_conv_pe_lb;

  localparam int DW   = 9;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int SH   = 0;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst, start, reuse_w, w_valid, pix_valid;
  logic [DW-1:0] w_data, pix_data, out_data;
  logic w_ready, pix_ready, out_valid, out_last, busy, done, sat_flag;

  always #5 clk = ~clk;

  conv_pe_lb #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  int cur_w [9];
  int cur_p [NPIX];
  int exp_val [NOUT];
  bit exp_sat;
  int got_data[$], got_last[$], got_cyc[$], launch_cyc[$];
  int acc_total = 0, acc_base = 0, w_rdy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int base_out, base_launch, base_w, base_done;
  bit timeout;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    int k;
    if (!rst) begin
      if (out_valid) begin
        got_data.push_back(int'($signed(out_data)));
        got_last.push_back(int'(out_last));
        got_cyc.push_back(cyc);
      end
      if (pix_valid && pix_ready) begin
        k = acc_total - acc_base;
        if ((k / W) >= 2 && (k % W) >= 2) launch_cyc.push_back(cyc);
        acc_total <= acc_total + 1;
      end
      if (w_ready) w_rdy_cnt <= w_rdy_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  function automatic int got_at(input int i);
    return (base_out + i < got_data.size()) ? got_data[base_out + i] : -99999;
  endfunction

  // Reference: valid (no padding) correlation, arithmetic shift, clamp to signed DW range.
  function automatic void build_expected();
    int k = 0;
    exp_sat = 1'b0;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        longint s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += longint'(cur_w[3*i+j]) * longint'(cur_p[(r-2+i)*W + (c-2+j)]);
        s = s >>> SH;
        if (s > (1 << (DW-1)) - 1) begin s = (1 << (DW-1)) - 1; exp_sat = 1'b1; end
        else if (s < -(1 << (DW-1))) begin s = -(1 << (DW-1)); exp_sat = 1'b1; end
        exp_val[k] = int'(s);
        k++;
      end
  endfunction

  task automatic mark_bases();
    base_out    = got_data.size();
    base_launch = launch_cyc.size();
    base_w      = w_rdy_cnt;
    base_done   = done_cnt;
    acc_base    = acc_total;
  endtask

  // gap: 0 = continuous, 1 = pix_valid every other cycle, 2 = random gaps on both streams
  task automatic run_frame(input bit reuse, input int gap);
    int k, t;
    timeout = 1'b0;
    mark_bases();
    start = 1'b1; reuse_w = reuse;
    @(posedge clk); #1;
    start = 1'b0; reuse_w = 1'b0;
    if (!reuse) begin
      k = 0; t = 0;
      while (k < 9 && t < 500) begin
        w_valid = (gap != 2) || ($urandom_range(3) != 0);
        w_data  = DW'(cur_w[k]);
        @(negedge clk);
        if (w_valid && w_ready) k++;
        @(posedge clk); #1;
        t++;
      end
      w_valid = 1'b0;
      if (k < 9) timeout = 1'b1;
    end
    k = 0; t = 0;
    while (k < NPIX && t < 500) begin
      case (gap)
        0:       pix_valid = 1'b1;
        1:       pix_valid = (t % 2 == 0);
        default: pix_valid = ($urandom_range(2) != 0);
      endcase
      pix_data = DW'(cur_p[k]);
      @(negedge clk);
      if (pix_valid && pix_ready) k++;
      @(posedge clk); #1;
      t++;
    end
    pix_valid = 1'b0;
    if (k < NPIX) timeout = 1'b1;
    t = 0;
    while (busy && t < 50) begin @(posedge clk); #1; t++; end
    if (busy) timeout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; reuse_w = 1'b0; w_valid = 1'b0; pix_valid = 1'b0;
    w_data = '0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (w_ready !== 1'b0)   begin errors++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
    checks++; if ({out_valid, out_last, done, sat_flag} !== 4'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {out_valid, out_last, done, sat_flag}); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    int e [4] = '{54, 63, 90, 99};
    int nlast = 0;
    for (int i = 0; i < 9; i++) cur_w[i] = 1;
    for (int i = 0; i < NPIX; i++) cur_p[i] = i + 1;
    run_frame(1'b0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ones_timeout: got %b want 0", timeout); end
    checks++; if (got_data.size() - base_out !== NOUT)
      begin errors++; $display("FAIL ones_count: got %0d want %0d", got_data.size() - base_out, NOUT); end
    for (int i = 0; i < NOUT; i++) begin
      checks++; if (got_at(i) !== e[i]) begin errors++; $display("FAIL ones_val[%0d]: got %0d want %0d", i, got_at(i), e[i]); end
    end
    for (int i = base_out; i < got_last.size(); i++) nlast += got_last[i];
    checks++; if (nlast !== 1 || got_last[got_last.size()-1] !== 1)
      begin errors++; $display("FAIL ones_last: got count %0d want 1 on final", nlast); end
    checks++; if (done_cnt - base_done !== 1) begin errors++; $display("FAIL ones_done_cnt: got %0d want 1", done_cnt - base_done); end
    checks++; if (done_cyc !== got_cyc[got_cyc.size()-1] + 1)
      begin errors++; $display("FAIL ones_done_cycle: got %0d want %0d", done_cyc, got_cyc[got_cyc.size()-1] + 1); end
    checks++; if (w_rdy_cnt - base_w < 9) begin errors++; $display("FAIL ones_w_ready: got %0d cycles want >=9", w_rdy_cnt - base_w); end
    checks++; if (busy !== 1'b0 || sat_flag !== 1'b0) begin errors++; $display("FAIL ones_idle: got busy %b sat %b want 0 0", busy, sat_flag); end
    checks++; if ($signed(out_data) !== 99) begin errors++; $display("FAIL ones_hold: got %0d want 99", $signed(out_data)); end
  endtask

  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) cur_w[i] = (pass == 0) ? 100 : -100;
      for (int i = 0; i < NPIX; i++) cur_p[i] = 100;
      run_frame(1'b0, 0);
      checks++; if (got_data.size() - base_out !== NOUT)
        begin errors++; $display("FAIL sat%0d_count: got %0d want %0d", pass, got_data.size() - base_out, NOUT); end
      for (int i = 0; i < NOUT; i++) begin
        checks++; if (got_at(i) !== ((pass == 0) ? 255 : -256))
          begin errors++; $display("FAIL sat%0d_val[%0d]: got %0d want %0d", pass, i, got_at(i), (pass == 0) ? 255 : -256); end
      end
      checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat%0d_flag: got %b want 1", pass, sat_flag); end
    end
  endtask

  task automatic test_center();
    int e [4] = '{6, 7, 10, 11};
    for (int i = 0; i < 9; i++) cur_w[i] = (i == 4) ? 1 : 0;
    for (int i = 0; i < NPIX; i++) cur_p[i] = i + 1;
    run_frame(1'b0, 0);
    for (int i = 0; i < NOUT; i++) begin
      checks++; if (got_at(i) !== e[i]) begin errors++; $display("FAIL center_val[%0d]: got %0d want %0d", i, got_at(i), e[i]); end
    end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL center_sat_cleared: got %b want 0", sat_flag); end
  endtask

  task automatic test_gaps();
    int e [4] = '{54, 63, 90, 99};
    for (int i = 0; i < 9; i++) cur_w[i] = 1;
    for (int i = 0; i < NPIX; i++) cur_p[i] = i + 1;
    run_frame(1'b0, 1);
    checks++; if (launch_cyc.size() - base_launch !== NOUT || got_cyc.size() - base_out !== NOUT)
      begin errors++; $display("FAIL gaps_count: got %0d outputs want %0d", got_cyc.size() - base_out, NOUT); end
    for (int i = 0; i < NOUT; i++) begin
      checks++; if (got_at(i) !== e[i]) begin errors++; $display("FAIL gaps_val[%0d]: got %0d want %0d", i, got_at(i), e[i]); end
      if (base_out + i < got_cyc.size() && base_launch + i < launch_cyc.size()) begin
        checks++;
        if (got_cyc[base_out+i] - launch_cyc[base_launch+i] !== 3)
          begin errors++; $display("FAIL gaps_latency[%0d]: got %0d want 3", i, got_cyc[base_out+i] - launch_cyc[base_launch+i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 9; i++)
        cur_w[i] = (f == 4) ? int'($urandom_range(511)) - 256 : int'($urandom_range(6)) - 3;
      for (int i = 0; i < NPIX; i++)
        cur_p[i] = (f == 4) ? int'($urandom_range(511)) - 256 : int'($urandom_range(80)) - 40;
      build_expected();
      run_frame(1'b0, 2);
      checks++; if (timeout !== 1'b0 || got_data.size() - base_out !== NOUT)
        begin errors++; $display("FAIL rand%0d_count: got %0d outputs timeout %b want %0d", f, got_data.size() - base_out, timeout, NOUT); end
      for (int i = 0; i < NOUT; i++) begin
        checks++; if (got_at(i) !== exp_val[i])
          begin errors++; $display("FAIL rand%0d_val[%0d]: got %0d want %0d", f, i, got_at(i), exp_val[i]); end
      end
      checks++; if (sat_flag !== exp_sat) begin errors++; $display("FAIL rand%0d_sat: got %b want %b", f, sat_flag, exp_sat); end
      checks++; if (done_cnt - base_done !== 1) begin errors++; $display("FAIL rand%0d_done: got %0d want 1", f, done_cnt - base_done); end
    end
  endtask

  task automatic test_reuse_and_abort();
    int e [4] = '{54, 63, 90, 99};
    int k, t;
    for (int i = 0; i < 9; i++) cur_w[i] = 1;
    for (int i = 0; i < NPIX; i++) cur_p[i] = i + 1;
    run_frame(1'b0, 0);
    run_frame(1'b1, 0);
    checks++; if (w_rdy_cnt - base_w !== 0) begin errors++; $display("FAIL reuse_w_ready: got %0d cycles want 0", w_rdy_cnt - base_w); end
    for (int i = 0; i < NOUT; i++) begin
      checks++; if (got_at(i) !== e[i]) begin errors++; $display("FAIL reuse_val[%0d]: got %0d want %0d", i, got_at(i), e[i]); end
    end
    // Abort after the first window has launched but before its result emerges.
    mark_bases();
    start = 1'b1; reuse_w = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reuse_w = 1'b0;
    k = 0; t = 0;
    while (k < 11 && t < 100) begin
      pix_valid = 1'b1;
      pix_data  = DW'(cur_p[k]);
      @(negedge clk);
      if (pix_ready) k++;
      @(posedge clk); #1;
      t++;
    end
    pix_valid = 1'b0;
    checks++; if (k !== 11) begin errors++; $display("FAIL abort_feed: got %0d pixels want 11", k); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL abort_async: got busy %b out_valid %b want 0 0", busy, out_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (got_data.size() - base_out !== 0)
      begin errors++; $display("FAIL abort_no_output: got %0d results want 0", got_data.size() - base_out); end
    run_frame(1'b1, 0);
    checks++; if (got_data.size() - base_out !== NOUT)
      begin errors++; $display("FAIL post_reset_count: got %0d want %0d", got_data.size() - base_out, NOUT); end
    for (int i = 0; i < NOUT; i++) begin
      checks++; if (got_at(i) !== 0) begin errors++; $display("FAIL post_reset_val[%0d]: got %0d want 0", i, got_at(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_saturation();
    test_center();
    test_gaps();
    test_random();
    test_reuse_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pe_lb.md
CONV_PE_LB -- requirements
Module: conv_pe_lb

Interface
REQ-001: Parameter DATA_W, default 9, signed two's-complement width of pixels, weights and results.
REQ-002: Parameter IMG_W, default 10, pixels per image row; legal range is 3 or more.
REQ-003: Parameter IMG_H, default 10, rows per image; legal range is 3 or more.
REQ-004: Parameter SHIFT, default 0, arithmetic right shift applied to the full-precision sum before saturation.
REQ-005: clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-006: rst  in  1  asynchronous reset, active-high.
REQ-007: start  in  1  single-cycle request to begin one frame.
REQ-008: reuse_w  in  1  sampled with start; when high, the block SHALL skip weight loading.
REQ-009: w_valid / w_data  in  1 / DATA_W  weight stream, row-major order w[0]..w[8].
REQ-010: w_ready  out  1  asserted while weights are being accepted.
REQ-011: pix_valid / pix_data  in  1 / DATA_W  pixel stream, raster order.
REQ-012: pix_ready  out  1  asserted while pixels are being accepted.
REQ-013: out_valid / out_data  out  1 / DATA_W  convolution result stream.
REQ-014: out_last  out  1  marks the final result of the frame.
REQ-015: busy / done / sat_flag  out  1 each  meaning: not IDLE / one-cycle frame-complete pulse / sticky saturation indicator.

Function
REQ-016: The state machine SHALL have the states IDLE, LOAD_W, RUN, FLUSH and DONE; busy SHALL be 1 in every state except IDLE.
REQ-017: In IDLE, start=1 SHALL move to RUN if reuse_w=1 and to LOAD_W otherwise, and SHALL clear sat_flag; start SHALL be ignored in any other state.
REQ-018: In LOAD_W, w_ready SHALL be 1, and each cycle with w_valid=1 SHALL store w_data into w[k] with k counting 0 to 8.
REQ-019: Acceptance of w[8] SHALL move the state to RUN on the next cycle; w_valid outside LOAD_W SHALL be ignored.
REQ-020: Weights SHALL be retained across frames until reset or the next LOAD_W.
REQ-021: In RUN, pix_ready SHALL be 1; a pixel is accepted on a cycle with pix_valid=1 and SHALL shift into two IMG_W-deep line buffers and a 3x3 window register; pix_valid outside RUN SHALL be ignored.
REQ-022: Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance per accepted pixel; col SHALL wrap to 0 with row incrementing.
REQ-023: An accepted pixel at row>=2 and col>=2 SHALL launch one window covering rows row-2..row and cols col-2..col, with w[0] applied to the top-left pixel and w[8] to the bottom-right; no padding SHALL be applied, so a frame yields (IMG_W-2)*(IMG_H-2) results.
REQ-024: Pipeline stage 1 SHALL form nine full-precision 2*DATA_W-bit signed products.
REQ-025: Pipeline stage 2 SHALL form three row partial sums.
REQ-026: Pipeline stage 3 SHALL form the 2*DATA_W+4-bit sum, shift it arithmetically right by SHIFT, clamp it to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and register out_data.
REQ-027: out_valid SHALL assert exactly 3 cycles after the accepting cycle; the pipeline SHALL never stall, so gaps in pix_valid SHALL appear as gaps in out_valid.
REQ-028: Whenever the clamp in REQ-026 changes the value, sat_flag SHALL be set and SHALL hold until the next start or reset.
REQ-029: Acceptance of the pixel at (IMG_H-1, IMG_W-1) SHALL move the state to FLUSH with pix_ready=0.
REQ-030: out_last SHALL assert together with out_valid for that pixel's result; the state SHALL then go to DONE for one cycle with done=1, then to IDLE.
REQ-031: When out_valid=0, out_data SHALL hold its last value.

Reset
REQ-032: On rst=1, all outputs, counters, line buffers, the window, pipeline registers and weights SHALL clear to 0 and the state SHALL go to IDLE, asynchronously.
REQ-033: A reset asserted mid-frame SHALL abort the frame, and no out_valid SHALL follow from pixels accepted before the reset.

Verification
REQ-034: IMG 4x4, SHIFT 0, all weights 1, pixels 1..16 -> out_data 54, 63, 90, 99, with out_last on 99, then done pulse, then busy=0.
REQ-035: Same frame with w[4]=1 and all other weights 0 -> outputs 6, 7, 10, 11.
REQ-036: DATA_W 9, weights all 100, pixels all 100 -> every output 255 and sat_flag=1; with weights all -100 -> every output -256.
REQ-037: Frame of REQ-034 with pix_valid toggled every other cycle -> identical values, each out_valid exactly 3 cycles after its accepting cycle.
REQ-038: After the frame of REQ-034, start with reuse_w=1 -> w_ready never asserts and outputs match REQ-034; then rst pulsed mid-RUN -> busy=0 and no further out_valid, and a following reuse_w frame -> all outputs 0.
